// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator slice.
package mac_pkg;

    localparam int PRODUCT_W   = 16;
    localparam int ACC_W_DEF   = 24;
    localparam int N_TERMS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_sat_add.sv
// ACC_W-bit adder with carry-out; clamps to all-ones on carry when MAC_SAT_EN is defined.
module mac_sat_add #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] sum_wide_s;

    // One extra bit captures the carry; the sum either wraps or clamps.
    always_comb begin
        sum_wide_s = {1'b0, acc} + {1'b0, addend};
        carry      = sum_wide_s[ACC_W];
`ifdef MAC_SAT_EN
        if (sum_wide_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = sum_wide_s[ACC_W-1:0];
        end
`else
        sum = sum_wide_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS unsigned products per request and holds the result until consumed.
// Optional saturation on overflow is enabled by defining MAC_SAT_EN.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 ovf
);

    localparam int               CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t             state_r, state_s;
    logic [ACC_W-1:0]   acc_r, acc_s, sum_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               ovf_r, ovf_s, carry_s;
    logic               in_ready_r, out_valid_r;

    mac_sat_add #(.ACC_W(ACC_W)) u_add (
        .acc    (acc_r),
        .addend (ACC_W'(product)),
        .sum    (sum_s),
        .carry  (carry_s)
    );

    // Next-state and datapath update selection.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s   = {ACC_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    ovf_s   = 1'b0;
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                // in_ready is high throughout ACCUM, so in_valid alone accepts a beat.
                if (in_valid) begin
                    acc_s = sum_s;
                    cnt_s = cnt_r + CNT_W'(1);
                    ovf_s = ovf_r | carry_s;
                    if (cnt_r == LAST_CNT) begin
                        state_s = HOLD;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                acc_s   = {ACC_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                ovf_s   = 1'b0;
            end
        endcase
    end

    // State, datapath and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s == ACCUM);
            out_valid_r <= (state_s == HOLD);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign acc_out   = acc_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default-size table plus a 16-bit/2-term overflow instance.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, out_ready;
    logic [15:0] product;
    logic        in_ready, out_valid, ovf;
    logic [23:0] acc_out;

    logic        sm_start, sm_in_valid, sm_out_ready;
    logic [15:0] sm_product;
    logic        sm_in_ready, sm_out_valid, sm_ovf;
    logic [15:0] sm_acc_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] product;
        bit          bubbles;
        logic [23:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

`ifdef MAC_SAT_EN
    localparam logic [15:0] SM_OVF_ACC = 16'hFFFF;
`else
    localparam logic [15:0] SM_OVF_ACC = 16'h0001;
`endif

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    mac_accumulator #(.ACC_W(16), .N_TERMS(2)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (sm_start),
        .in_valid  (sm_in_valid),
        .in_ready  (sm_in_ready),
        .product   (sm_product),
        .out_valid (sm_out_valid),
        .out_ready (sm_out_ready),
        .acc_out   (sm_acc_out),
        .ovf       (sm_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [15:0] p, input bit bubbles,
                           input logic [23:0] exp_acc, input logic exp_ovf, input bit release_out);
        logic [31:0] partial;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accum_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            product  = p;
            tick();
            partial = 32'(p) * 32'(i + 1);
            if (i < 7) begin
                check("early_out_valid", {31'd0, out_valid}, 32'd0);
                check("partial_acc", {8'd0, acc_out}, partial);
                if (bubbles) begin
                    in_valid = 1'b0;
                    product  = 16'hDEAD;
                    tick();
                    check("bubble_acc", {8'd0, acc_out}, partial);
                    check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
                end
            end
        end
        in_valid = 1'b0;
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        check("done_acc", {8'd0, acc_out}, {8'd0, exp_acc});
        check("done_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end
    endtask

    task automatic small_txn(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] exp_acc, input logic exp_ovf);
        sm_start = 1'b1;
        tick();
        sm_start = 1'b0;
        check("sm_start_ovf_clear", {31'd0, sm_ovf}, 32'd0);
        sm_in_valid = 1'b1;
        sm_product  = p0;
        tick();
        check("sm_beat1_acc", {16'd0, sm_acc_out}, {16'd0, p0});
        check("sm_beat1_out_valid", {31'd0, sm_out_valid}, 32'd0);
        sm_product = p1;
        tick();
        sm_in_valid = 1'b0;
        check("sm_out_valid", {31'd0, sm_out_valid}, 32'd1);
        check("sm_acc", {16'd0, sm_acc_out}, {16'd0, exp_acc});
        check("sm_ovf", {31'd0, sm_ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFE01, 1'b0, 24'h07F008, 1'b0};
        vecs[1] = '{16'h0001, 1'b1, 24'h000008, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b0, 24'h07FFF8, 1'b0};
        vecs[3] = '{16'h0000, 1'b1, 24'h000000, 1'b0};
        vecs[4] = '{16'h0123, 1'b0, 24'h000918, 1'b0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; product = 16'h0000;
        sm_start = 1'b0; sm_in_valid = 1'b0; sm_out_ready = 1'b0; sm_product = 16'h0000;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_acc", {8'd0, acc_out}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("idle_no_start", {31'd0, in_ready}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].product, vecs[v].bubbles, vecs[v].exp_acc, vecs[v].exp_ovf, 1'b1);
        end

        // HOLD stability: ignored in_valid/start, then start coincident with exit.
        run_txn(16'hFE01, 1'b0, 24'h07F008, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            start    = (c == 2);
            product  = 16'h1234;
            tick();
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_acc", {8'd0, acc_out}, 32'h07F008);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("exit_out_valid", {31'd0, out_valid}, 32'd0);
        check("exit_start_ignored", {31'd0, in_ready}, 32'd0);
        tick();
        check("exit_stays_idle", {31'd0, in_ready}, 32'd0);

        // Small instance: clean sum, then an overflowing sum left in HOLD.
        small_txn(16'h0001, 16'h0002, 16'h0003, 1'b0);
        sm_out_ready = 1'b1;
        tick();
        sm_out_ready = 1'b0;
        check("sm_idle_out_valid", {31'd0, sm_out_valid}, 32'd0);
        small_txn(16'hFFFF, 16'h0002, SM_OVF_ACC, 1'b1);
        tick();
        check("sm_hold_ovf_sticky", {31'd0, sm_ovf}, 32'd1);

        // Asynchronous reset mid-ACCUM (main) and mid-HOLD (small).
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            product  = 16'h0010;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_acc", {8'd0, acc_out}, 32'h30);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_acc", {8'd0, acc_out}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_sm_out_valid", {31'd0, sm_out_valid}, 32'd0);
        check("async_rst_sm_ovf", {31'd0, sm_ovf}, 32'd0);
        check("async_rst_sm_acc", {16'd0, sm_acc_out}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            product  = 16'h0010;
            tick();
            check("post_rst_no_start_ready", {31'd0, in_ready}, 32'd0);
            check("post_rst_no_start_acc", {8'd0, acc_out}, 32'd0);
        end
        in_valid = 1'b0;
        run_txn(16'h0010, 1'b0, 24'h000080, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
